// File: rtl/wb_result_checker_pkg.sv
// Shared definitions for the writeback checker: checker state encoding and
// default widths/limits, reusable by benches that drive or observe it.
package wb_result_checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DONE    = 3'd2,
    ST_TIMEOUT = 3'd3
  } chk_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 5;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_TIMEOUT_CYC = 1000;

endpackage

// File: rtl/wb_exp_fifo.sv
// Generic synchronous FIFO.
// Ports: clk; reset (async, active-low); clear (sync flush);
//        push/push_data (write); pop (read, head on pop_data);
//        full, empty, count (occupancy).
// A push while full is accepted only when a pop happens in the same cycle.
module wb_exp_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == (AW+1)'(DEPTH));
  assign count    = cnt_q;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_result_checker.sv
// Programmable writeback checker for the mips_32 pipeline.
// Ports: clk; reset (async, active-low); clear (sync flush to IDLE);
//        exp_valid/exp_dest/exp_data/exp_ready: expected-writeback queue push;
//        start: begin checking; wb_valid/wb_dest/wb_data: register-file write tap;
//        state/done/pass: checker status; pass_count/fail_count: saturating
//        counters; extra_err: writeback seen with nothing expected;
//        first_fail_exp/act/idx: capture of the first mismatching compare.
module wb_result_checker
  import wb_result_checker_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CHECK_DEST  = 1,
  parameter int IGNORE_R0   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              exp_valid,
  input  logic [ADDR_W-1:0] exp_dest,
  input  logic [DATA_W-1:0] exp_data,
  output logic              exp_ready,
  input  logic              start,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [2:0]        state,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic              extra_err,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [DATA_W-1:0] first_fail_act,
  output logic [CNT_W-1:0]  first_fail_idx
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam int CW   = $clog2(DEPTH) + 1;

  chk_state_e         state_q;
  logic [WD_W-1:0]    wd_q;
  logic               pending_q;
  logic               ff_seen_q;
  logic [CNT_W-1:0]   pass_q;
  logic [CNT_W-1:0]   fail_q;
  logic [CNT_W-1:0]   idx_q;
  logic               extra_q;
  logic [DATA_W-1:0]  ffe_q;
  logic [DATA_W-1:0]  ffa_q;
  logic [CNT_W-1:0]   ffi_q;

  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0]  head_dest;
  logic [DATA_W-1:0]  head_data;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  logic in_run;
  logic wb_qual;
  logic pop_en;
  logic push_en;
  logic is_match;
  logic timeout_hit;
  logic occ_next_nz;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign {head_dest, head_data} = head;

  assign in_run   = (state_q == ST_RUN);
  assign wb_qual  = wb_valid && !((IGNORE_R0 != 0) && (wb_dest == '0));
  assign pop_en   = in_run && wb_qual && !fifo_empty;
  assign push_en  = exp_valid && (state_q == ST_IDLE || in_run) && (!fifo_full || pop_en);
  assign is_match = (head_data == wb_data) && ((CHECK_DEST == 0) || (head_dest == wb_dest));
  assign timeout_hit = (wd_q >= WD_W'(TIMEOUT_CYC - 1));
  // Occupancy after this edge is non-zero.
  assign occ_next_nz = push_en || (!fifo_empty && !(pop_en && fifo_count == CW'(1)));

  wb_exp_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push_en),
    .push_data ({exp_dest, exp_data}),
    .pop       (pop_en),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      pending_q <= 1'b0;
      ff_seen_q <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      idx_q     <= '0;
      extra_q   <= 1'b0;
      ffe_q     <= '0;
      ffa_q     <= '0;
      ffi_q     <= '0;
    end else if (clear) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      pending_q <= 1'b0;
      ff_seen_q <= 1'b0;
      pass_q    <= '0;
      fail_q    <= '0;
      idx_q     <= '0;
      extra_q   <= 1'b0;
      ffe_q     <= '0;
      ffa_q     <= '0;
      ffi_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_RUN;
            wd_q      <= '0;
            pending_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (wb_qual) begin
            if (!fifo_empty) begin
              if (is_match) begin
                pass_q <= sat_inc(pass_q);
              end else begin
                fail_q <= sat_inc(fail_q);
                if (!ff_seen_q) begin
                  ff_seen_q <= 1'b1;
                  ffe_q     <= head_data;
                  ffa_q     <= wb_data;
                  ffi_q     <= idx_q;
                end
              end
              idx_q <= idx_q + 1'b1;
            end else begin
              extra_q <= 1'b1;
              fail_q  <= sat_inc(fail_q);
            end
          end
          // Completion is judged one cycle after the pop (or a start in RUN)
          // so the final count update is visible before done rises.
          pending_q <= pop_en || start;
          if (wd_q != WD_W'(TIMEOUT_CYC)) wd_q <= wd_q + 1'b1;
          if (pending_q && fifo_empty && !push_en) state_q <= ST_DONE;
          else if (timeout_hit && occ_next_nz)     state_q <= ST_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  assign exp_ready      = !fifo_full;
  assign state          = state_q;
  assign done           = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
  assign pass           = (state_q == ST_DONE) && (fail_q == '0) && !extra_q;
  assign pass_count     = pass_q;
  assign fail_count     = fail_q;
  assign extra_err      = extra_q;
  assign first_fail_exp = ffe_q;
  assign first_fail_act = ffa_q;
  assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_wb_result_checker.sv
module tb_wb_result_checker;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        exp_valid;
  logic [4:0]  exp_dest;
  logic [31:0] exp_data;
  logic        exp_ready;
  logic        start;
  logic        wb_valid;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [2:0]  state;
  logic        done;
  logic        pass;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic        extra_err;
  logic [31:0] first_fail_exp;
  logic [31:0] first_fail_act;
  logic [15:0] first_fail_idx;

  wb_result_checker #(
    .DATA_W      (32),
    .ADDR_W      (5),
    .DEPTH       (DEPTH),
    .CNT_W       (16),
    .TIMEOUT_CYC (TIMEOUT),
    .CHECK_DEST  (1),
    .IGNORE_R0   (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .exp_valid      (exp_valid),
    .exp_dest       (exp_dest),
    .exp_data       (exp_data),
    .exp_ready      (exp_ready),
    .start          (start),
    .wb_valid       (wb_valid),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .state          (state),
    .done           (done),
    .pass           (pass),
    .pass_count     (pass_count),
    .fail_count     (fail_count),
    .extra_err      (extra_err),
    .first_fail_exp (first_fail_exp),
    .first_fail_act (first_fail_act),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; logic [4:0] d; logic [31:0] x; } item_t;
  typedef struct { item_t wb; item_t ps; bit st; } slot_t;
  typedef struct {
    logic [2:0]  st;
    logic        ps;
    logic [15:0] pc;
    logic [15:0] fc;
    logic        ex;
    logic [31:0] fe;
    logic [31:0] fa;
    logic [15:0] fi;
  } res_t;

  item_t pre_q[$];
  slot_t slot_q[$];
  res_t  sb[$];
  res_t  mon_e;
  logic  done_d = 1'b0;
  int    total = 0;
  int    bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic item_t mk(input logic [4:0] d, input logic [31:0] x);
    item_t it;
    it.v = 1'b1; it.d = d; it.x = x;
    return it;
  endfunction

  function automatic slot_t idle_slot();
    slot_t s;
    s.wb.v = 1'b0; s.wb.d = '0; s.wb.x = '0;
    s.ps.v = 1'b0; s.ps.d = '0; s.ps.x = '0;
    s.st = 1'b0;
    return s;
  endfunction

  // Reference: an ordered list of expected writebacks consumed by qualifying
  // writebacks; completion one cycle after the list drains.
  task automatic model(output res_t r);
    item_t q[$];
    item_t e;
    bit pend, fin, fin_now, popped, ffs;
    int unsigned ncmp;
    r.st = 0; r.ps = 0; r.pc = 0; r.fc = 0; r.ex = 0; r.fe = 0; r.fa = 0; r.fi = 0;
    pend = 0; fin = 0; ffs = 0; ncmp = 0;
    foreach (pre_q[i]) if (q.size() < DEPTH) q.push_back(pre_q[i]);
    foreach (slot_q[i]) begin
      if (!fin) begin
        fin_now = pend && q.size() == 0 && !slot_q[i].ps.v;
        popped = 0;
        if (slot_q[i].wb.v && slot_q[i].wb.d != 0) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            popped = 1;
            if (e.x == slot_q[i].wb.x && e.d == slot_q[i].wb.d) r.pc = r.pc + 1;
            else begin
              r.fc = r.fc + 1;
              if (!ffs) begin
                ffs = 1; r.fe = e.x; r.fa = slot_q[i].wb.x; r.fi = 16'(ncmp);
              end
            end
            ncmp++;
          end else begin
            r.ex = 1;
            r.fc = r.fc + 1;
          end
        end
        if (slot_q[i].ps.v && q.size() < DEPTH) q.push_back(slot_q[i].ps);
        pend = popped || slot_q[i].st;
        if (fin_now) fin = 1;
      end
    end
    if (!fin && pend && q.size() == 0) fin = 1;
    r.st = fin ? 3'd2 : (q.size() > 0 ? 3'd3 : 3'd1);
    r.ps = fin && r.fc == 0 && !r.ex;
  endtask

  task automatic idle_inputs();
    exp_valid = 0; exp_dest = 0; exp_data = 0;
    start = 0; wb_valid = 0; wb_dest = 0; wb_data = 0; clear = 0;
  endtask

  // Called at posedge+1 with the checker in IDLE and its queue empty.
  task automatic run_scen(input string nm, input int exp_cyc, input bit t1);
    res_t r;
    int   sz, run_cyc, want_cyc;
    model(r);
    sb.push_back(r);
    want_cyc = (r.st == 3'd3) ? TIMEOUT : exp_cyc;
    sz = 0;
    foreach (pre_q[i]) begin
      check({nm, "_exp_ready"}, 64'(exp_ready), 64'(sz < DEPTH));
      if (sz < DEPTH) sz++;
      exp_valid = 1; exp_dest = pre_q[i].d; exp_data = pre_q[i].x;
      @(posedge clk); #1;
    end
    exp_valid = 0;
    start = 1;
    @(posedge clk);
    run_cyc = 0;
    #1 start = 0;
    foreach (slot_q[i]) begin
      wb_valid = slot_q[i].wb.v; wb_dest = slot_q[i].wb.d; wb_data = slot_q[i].wb.x;
      exp_valid = slot_q[i].ps.v; exp_dest = slot_q[i].ps.d; exp_data = slot_q[i].ps.x;
      start = slot_q[i].st;
      @(posedge clk); run_cyc++; #1;
    end
    idle_inputs();
    if (t1) begin
      check({nm, "_cnt_upd"}, 64'(pass_count), 64'd1);
      check({nm, "_done_after_cnt"}, 64'(done), 64'd0);
    end
    while (!done && run_cyc < 200) begin
      @(posedge clk); run_cyc++; #1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_done_wait: got no done want done within 200 cycles", nm);
      sb.delete();
    end else begin
      if (want_cyc != 0) check({nm, "_done_cycle"}, 64'(run_cyc), 64'(want_cyc));
      @(negedge clk); #1;
      if (sb.size() != 0) begin
        total++; bad++;
        $display("FAIL %s_sb_drain: got %0d pending want 0", nm, sb.size());
        sb.delete();
      end
    end
    // Clear together with every other input; clear must win.
    @(posedge clk); #1;
    clear = 1; start = 1; exp_valid = 1; exp_dest = 5'd7; exp_data = $urandom;
    wb_valid = 1; wb_dest = 5'd7; wb_data = 32'h1;
    @(posedge clk); #1;
    idle_inputs();
    check({nm, "_clr_status"}, 64'({state, done, pass, extra_err, pass_count, fail_count}), 64'd0);
    check({nm, "_clr_capture"}, {first_fail_exp, first_fail_act}, 64'd0);
    check({nm, "_clr_idx_ready"}, 64'({first_fail_idx, exp_ready}), 64'd1);
  endtask

  task automatic gen_random();
    int unsigned n, k;
    item_t it;
    slot_t s;
    pre_q.delete(); slot_q.delete();
    n = $urandom_range(DEPTH, 1);
    for (int unsigned i = 0; i < n; i++) begin
      it = mk(5'($urandom_range(31, 1)), $urandom);
      pre_q.push_back(it);
    end
    k = ($urandom_range(3, 0) == 0) ? $urandom_range(n - 1, 0) : n;
    for (int unsigned i = 0; i < k; i++) begin
      if ($urandom_range(2, 0) == 0) begin
        s = idle_slot();
        if ($urandom_range(1, 0) == 1) s.wb = mk(5'd0, $urandom);
        slot_q.push_back(s);
      end
      s = idle_slot();
      s.wb = pre_q[i];
      case ($urandom_range(3, 0))
        0: s.wb.x = s.wb.x ^ ($urandom | 32'd1);
        1: s.wb.d = (s.wb.d % 5'd31) + 5'd1;
        default: ;
      endcase
      slot_q.push_back(s);
    end
  endtask

  // Scoreboard monitor: each completion is compared with the oldest prediction.
  always @(negedge clk) begin
    if (done && !done_d) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL res_unexpected: got done with state %0d want no completion", state);
      end else begin
        mon_e = sb.pop_front();
        check("res_state", 64'(state), 64'(mon_e.st));
        check("res_pass", 64'(pass), 64'(mon_e.ps));
        check("res_pass_count", 64'(pass_count), 64'(mon_e.pc));
        check("res_fail_count", 64'(fail_count), 64'(mon_e.fc));
        check("res_extra_err", 64'(extra_err), 64'(mon_e.ex));
        check("res_ff_exp", 64'(first_fail_exp), 64'(mon_e.fe));
        check("res_ff_act", 64'(first_fail_act), 64'(mon_e.fa));
        check("res_ff_idx", 64'(first_fail_idx), 64'(mon_e.fi));
      end
    end
    done_d = done;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish within 200000 time units");
    $fatal(1, "bench did not finish");
  end

  initial begin
    slot_t s;
    reset = 0;
    idle_inputs();
    #12;
    check("rst_status", 64'({state, done, pass, extra_err, pass_count, fail_count}), 64'd0);
    check("rst_idx_ready", 64'({first_fail_idx, exp_ready}), 64'd1);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    check("rst_hold_idle", 64'({state, done, exp_ready}), 64'd1);

    // Single expected write, matched.
    pre_q.delete(); slot_q.delete();
    pre_q.push_back(mk(5'd3, 32'h3));
    s = idle_slot(); s.wb = mk(5'd3, 32'h3); slot_q.push_back(s);
    run_scen("t1", 2, 1);

    // Three writes, middle one corrupted.
    pre_q.delete(); slot_q.delete();
    pre_q.push_back(mk(5'd1, 32'hA));
    pre_q.push_back(mk(5'd2, 32'hB));
    pre_q.push_back(mk(5'd3, 32'hC));
    s = idle_slot(); s.wb = mk(5'd1, 32'hA);  slot_q.push_back(s);
    s = idle_slot(); s.wb = mk(5'd2, 32'hFF); slot_q.push_back(s);
    s = idle_slot(); s.wb = mk(5'd3, 32'hC);  slot_q.push_back(s);
    run_scen("t2", 0, 0);

    // Fill to DEPTH, one dropped push, then push+pop while full.
    pre_q.delete(); slot_q.delete();
    for (int i = 0; i <= DEPTH; i++) pre_q.push_back(mk(5'(i % 31 + 1), 32'h1000 + 32'(i)));
    for (int i = 0; i < DEPTH; i++) begin
      s = idle_slot(); s.wb = pre_q[i];
      if (i == 0) s.ps = mk(5'd9, 32'hABCD);
      slot_q.push_back(s);
    end
    s = idle_slot(); s.wb = mk(5'd9, 32'hABCD); slot_q.push_back(s);
    run_scen("t3", 0, 0);

    // R0 write ignored, then a write after the queue has drained.
    pre_q.delete(); slot_q.delete();
    pre_q.push_back(mk(5'd1, 32'h11));
    s = idle_slot(); s.wb = mk(5'd0, 32'h5);  slot_q.push_back(s);
    s = idle_slot(); s.wb = mk(5'd1, 32'h11); slot_q.push_back(s);
    s = idle_slot(); s.wb = mk(5'd2, 32'h22); slot_q.push_back(s);
    run_scen("t4", 3, 0);

    // Watchdog expiry with one entry outstanding.
    pre_q.delete(); slot_q.delete();
    pre_q.push_back(mk(5'd4, 32'h44));
    run_scen("t5", 0, 0);

    // Start while running with an empty queue.
    pre_q.delete(); slot_q.delete();
    s = idle_slot(); s.st = 1; slot_q.push_back(s);
    run_scen("t6", 2, 0);

    // Asynchronous reset in the middle of a run.
    exp_valid = 1; exp_dest = 5'd1; exp_data = 32'h1;
    @(posedge clk); #1;
    exp_dest = 5'd2; exp_data = 32'h2;
    @(posedge clk); #1;
    exp_valid = 0; start = 1;
    @(posedge clk); #1;
    start = 0; wb_valid = 1; wb_dest = 5'd1; wb_data = 32'h1;
    @(posedge clk); #1;
    wb_valid = 0;
    check("t7_pre_reset", 64'({state, pass_count}), {45'd0, 3'd1, 16'd1});
    @(negedge clk); #2;
    reset = 0;
    #1;
    check("t7_async_status", 64'({state, done, pass, extra_err, pass_count, fail_count}), 64'd0);
    check("t7_async_ready", 64'(exp_ready), 64'd1);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    pre_q.delete(); slot_q.delete();
    pre_q.push_back(mk(5'd5, 32'h5));
    s = idle_slot(); s.wb = mk(5'd5, 32'h5); slot_q.push_back(s);
    run_scen("t7_after", 2, 0);

    for (int i = 0; i < 15; i++) begin
      gen_random();
      run_scen("rnd", 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_result_checker.md
Name: wb_result_checker

Overview:
- Synthesizable, parametrised writeback checker for the mips_32 pipeline.
- Replaces the fixed single-value "expected == 3" check with a programmable, ordered queue of expected register writebacks (dest, data).
- Provides pass/fail counters, first-failure capture, an extra-write error flag and a watchdog timeout.
- Sits beside the core, tapping reg_write_dest/reg_write_data plus the WB write enable; usable in benches and on FPGA.

Parameters:
- DATA_W, 32: writeback data width.
- ADDR_W, 5: register address width.
- DEPTH, 16: expected-queue entries (power of 2, ≥2).
- CNT_W, 16: width of pass/fail counters (saturating).
- TIMEOUT_CYC, 1000: RUN cycles allowed before TIMEOUT.
- CHECK_DEST, 1: 1 = compare dest and data; 0 = data only.
- IGNORE_R0, 1: 1 = WB writes to register 0 are not checked.

Ports:
- clk, in, 1: clock, rising edge.
- reset, in, 1: asynchronous active-low reset.
- clear, in, 1: synchronous flush; returns to IDLE.
- exp_valid, in, 1: push an expected entry.
- exp_dest, in, ADDR_W: expected destination register.
- exp_data, in, DATA_W: expected data.
- exp_ready, out, 1: queue not full.
- start, in, 1: begin checking.
- wb_valid, in, 1: core register-file write enable.
- wb_dest, in, ADDR_W: reg_write_dest.
- wb_data, in, DATA_W: reg_write_data.
- state, out, 3: {IDLE=0, RUN=1, DONE=2, TIMEOUT=3}.
- done, out, 1: state is DONE or TIMEOUT.
- pass, out, 1: DONE and fail_count==0 and !extra_err.
- pass_count, out, CNT_W: matched writebacks.
- fail_count, out, CNT_W: mismatched writebacks.
- extra_err, out, 1: writeback arrived with the queue empty.
- first_fail_exp, out, DATA_W: expected data of the first mismatch.
- first_fail_act, out, DATA_W: actual data of the first mismatch.
- first_fail_idx, out, CNT_W: compare index of the first mismatch (0-based).

Behaviour:
- Reset (reset=0, async): state=IDLE, queue empty, exp_ready=1, all counters/flags/capture registers 0, done=0, pass=0.
- clear: same effect as reset but synchronous; clear wins over every other input in that cycle.
- Queue:
  - FIFO with DEPTH entries.
  - Push when exp_valid && exp_ready.
  - A push while full is dropped; exp_ready=0 whenever full.
  - Pushes are accepted in IDLE and RUN, ignored in DONE/TIMEOUT.
  - Push and pop in the same cycle are both performed; occupancy is unchanged, including when full.
- IDLE: start=1 → RUN next cycle; watchdog loaded with 0. wb_valid is ignored.
- RUN, qualifying writeback:
  - A writeback qualifies when wb_valid=1 and !(IGNORE_R0 && wb_dest==0).
  - If the queue is non-empty, the head is popped and compared.
  - Match rule: data equal and (CHECK_DEST==0 or dest equal).
  - Match → pass_count+1. Mismatch → fail_count+1; if this is the first mismatch, capture exp, act and idx.
  - Counters update one cycle after wb_valid (registered compare).
  - If the queue is empty: extra_err set (sticky until clear/reset) and fail_count+1.
- RUN, completion and timeout:
  - Watchdog increments every RUN cycle.
  - Queue empty after a pop and no push in that cycle → DONE next cycle.
  - Watchdog reaching TIMEOUT_CYC with the queue non-empty → TIMEOUT.
  - If completion and timeout occur in the same cycle, DONE wins.
- start in RUN is ignored. A start in RUN with an already-empty queue → DONE after 1 cycle.
- DONE/TIMEOUT: hold all outputs; only clear or reset leaves.
- Counters saturate at 2^CNT_W−1. Compare index wraps modulo 2^CNT_W.
- Reset mid-RUN discards the queue and all results immediately.

Decomposition:
- Shared package: the state enum, default widths and the TIMEOUT_CYC default, reused by benches.
- Sub-module: wb_exp_fifo, a generic sync FIFO with async active-low reset, full/empty flags and simultaneous push/pop.

Test Plan:
- Push (3,0x3), start, wb (3,0x3) → pass_count=1, fail=0; DONE 1 cycle after the count update; pass=1.
- Push (1,0xA),(2,0xB),(3,0xC), start, wb (1,0xA),(2,0xFF),(3,0xC) → pass=2, fail=1, first_fail_exp=0xB, act=0xFF, idx=1, pass=0.
- Fill DEPTH=16 entries, push a 17th → exp_ready=0, 17th dropped; simultaneous push+pop while full → occupancy stays 16.
- IGNORE_R0=1, wb (0,0x5) during RUN → no pop, no count change. Then a wb with the queue empty → extra_err=1, fail_count+1.
- TIMEOUT_CYC=10, push 1 entry, start, no wb → state=TIMEOUT at RUN cycle 10, done=1, pass=0. Then clear → IDLE with all zeros.
- reset asserted mid-RUN with 2 entries queued → outputs zero asynchronously, queue empty, state=IDLE.
